axis_fifo: RTL and testbench

AXIS_FIFO -- requirements
Module: axis_fifo

---
 rtl/axis_pkg.sv | 22 ++
 rtl/axis_if.sv | 29 ++
 rtl/axis_fifo_mem.sv | 28 ++
 rtl/axis_fifo.sv | 129 ++++++++++++
 tb/tb_axis_fifo.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pkg.sv
// Shared AXI-Stream beat type and default field widths for axis_if and axis_fifo.
package axis_pkg;

    localparam int DATA_W = 32;
    localparam int KEEP_W = DATA_W / 8;
    localparam int ID_W   = 4;
    localparam int DEST_W = 4;
    localparam int USER_W = 1;

    typedef struct packed {
        logic [DATA_W-1:0] tdata;
        logic [KEEP_W-1:0] tstrb;
        logic [KEEP_W-1:0] tkeep;
        logic              tlast;
        logic [ID_W-1:0]   tid;
        logic [DEST_W-1:0] tdest;
        logic [USER_W-1:0] tuser;
    } axis_beat_t;

    localparam int BEAT_W = $bits(axis_beat_t);

endpackage

// File: rtl/axis_if.sv
// AXI-Stream bundle; default widths follow axis_pkg so beats map onto axis_beat_t.
interface axis_if #(
    parameter int DATA_W = axis_pkg::DATA_W,
    parameter int ID_W   = axis_pkg::ID_W,
    parameter int DEST_W = axis_pkg::DEST_W,
    parameter int USER_W = axis_pkg::USER_W
) ();

    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tstrb;
    logic [DATA_W/8-1:0]   tkeep;
    logic                  tlast;
    logic [ID_W-1:0]       tid;
    logic [DEST_W-1:0]     tdest;
    logic [USER_W-1:0]     tuser;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        output tready
    );

endinterface

// File: rtl/axis_fifo_mem.sv
// Beat storage: DEPTH x axis_beat_t, synchronous write, asynchronous read.
module axis_fifo_mem
    import axis_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              aclk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  axis_beat_t        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output axis_beat_t        rd_data
);

    axis_beat_t mem [DEPTH];

    // NOTE: the array has no reset; pointers define which entries are live, and
    // a reset on storage would turn the RAM into a wide bank of flops.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_fifo.sv
// Registered-output AXI-Stream FIFO. Define AXIS_FIFO_PKT_MODE_EN for
// store-and-forward release with a cut-through escape when full of one partial packet.
module axis_fifo
    import axis_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     aclk,
    input  logic                     areset,
    axis_if.slave                    s_axis,
    axis_if.master                   m_axis,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W-1:0] wr_ptr_next, rd_ptr_next;
    logic             ready_q, valid_q;
    logic             valid_next;
    logic             push, pop;
    logic             empty_next, full_next;
    logic             load_head;
    axis_beat_t       in_beat, rd_data, head_q, head_next;

    assign in_beat.tdata = s_axis.tdata;
    assign in_beat.tstrb = s_axis.tstrb;
    assign in_beat.tkeep = s_axis.tkeep;
    assign in_beat.tlast = s_axis.tlast;
    assign in_beat.tid   = s_axis.tid;
    assign in_beat.tdest = s_axis.tdest;
    assign in_beat.tuser = s_axis.tuser;

    assign push = s_axis.tvalid && ready_q;
    assign pop  = valid_q && m_axis.tready;

    assign wr_ptr_next = wr_ptr + PTR_W'(push);
    assign rd_ptr_next = rd_ptr + PTR_W'(pop);

    assign empty_next = (wr_ptr_next == rd_ptr_next);
    assign full_next  = (wr_ptr_next[ADDR_W-1:0] == rd_ptr_next[ADDR_W-1:0]) &&
                        (wr_ptr_next[ADDR_W] != rd_ptr_next[ADDR_W]);

    assign level = wr_ptr - rd_ptr;

    axis_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .aclk    (aclk),
        .wr_en   (push),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (in_beat),
        .rd_addr (rd_ptr_next[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

    // The next head is normally read from storage, but when it is the beat being
    // written on this very edge it is taken straight from the input (no bubble).
    // NOTE: every signal driven here gets its default first so no latch is inferred.
    always_comb begin
        head_next = rd_data;
        if (push && (rd_ptr_next[ADDR_W-1:0] == wr_ptr[ADDR_W-1:0])) begin
            head_next = in_beat;
        end
    end

    // Head only moves when it is consumed or not yet presented, keeping payload
    // stable under backpressure.
    assign load_head = (pop || !valid_q) && !empty_next;

`ifdef AXIS_FIFO_PKT_MODE_EN
    logic [PTR_W-1:0] pkt_cnt, pkt_cnt_next;
    logic             cut_q, cut_next;
    logic             push_last, pop_last;

    assign push_last    = push && s_axis.tlast;
    assign pop_last     = pop && head_q.tlast;
    assign pkt_cnt_next = pkt_cnt + PTR_W'(push_last) - PTR_W'(pop_last);

    // Full with no complete packet would deadlock; stream out until a tlast leaves.
    assign cut_next   = (cut_q && !pop_last) || (full_next && (pkt_cnt_next == '0));
    assign valid_next = !empty_next && ((pkt_cnt_next != '0) || cut_next);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            pkt_cnt <= '0;
            cut_q   <= 1'b0;
        end else begin
            pkt_cnt <= pkt_cnt_next;
            cut_q   <= cut_next;
        end
    end
`else
    assign valid_next = !empty_next;
`endif

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            head_q  <= '0;
        end else begin
            wr_ptr  <= wr_ptr_next;
            rd_ptr  <= rd_ptr_next;
            ready_q <= !full_next;
            valid_q <= valid_next;
            if (load_head) begin
                head_q <= head_next;
            end
        end
    end

    assign s_axis.tready = ready_q;

    assign m_axis.tvalid = valid_q;
    assign m_axis.tdata  = head_q.tdata;
    assign m_axis.tstrb  = head_q.tstrb;
    assign m_axis.tkeep  = head_q.tkeep;
    assign m_axis.tlast  = head_q.tlast;
    assign m_axis.tid    = head_q.tid;
    assign m_axis.tdest  = head_q.tdest;
    assign m_axis.tuser  = head_q.tuser;

endmodule

// File: tb/tb_axis_fifo.sv
// Scoreboard bench for axis_fifo: accepted beats are queued, a monitor compares outputs.
module tb_axis_fifo;
    import axis_pkg::*;

    localparam int DEPTH = 16;

    logic       aclk;
    logic       areset;
    logic [4:0] level;

    axis_if s_if ();
    axis_if m_if ();

    axis_fifo #(.DEPTH(DEPTH)) dut (
        .aclk   (aclk),
        .areset (areset),
        .s_axis (s_if),
        .m_axis (m_if),
        .level  (level)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    axis_beat_t exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_pushed = 0;
    int n_popped = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic axis_beat_t mk(input logic [31:0] d, input logic last);
        axis_beat_t b;
        b       = '0;
        b.tdata = d;
        b.tstrb = d[3:0];
        b.tkeep = ~d[7:4];
        b.tlast = last;
        b.tid   = d[11:8];
        b.tdest = d[15:12];
        b.tuser = d[16];
        return b;
    endfunction

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input axis_beat_t b);
        int t = 0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = b.tdata;
        s_if.tstrb  = b.tstrb;
        s_if.tkeep  = b.tkeep;
        s_if.tlast  = b.tlast;
        s_if.tid    = b.tid;
        s_if.tdest  = b.tdest;
        s_if.tuser  = b.tuser;
        forever begin
            @(negedge aclk);
            if (s_if.tready) begin
                exp_q.push_back(b);
                n_pushed++;
                tick();
                break;
            end
            tick();
            t++;
            if (t > 200) begin
                check("send_timeout", 64'(s_if.tready), 64'd1);
                break;
            end
        end
        s_if.tvalid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            @(negedge aclk);
            t++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    // Monitor: a handshake seen mid-cycle completes on the next rising edge.
    always @(negedge aclk) begin
        axis_beat_t got;
        if (!areset && m_if.tvalid && m_if.tready) begin
            got.tdata = m_if.tdata;
            got.tstrb = m_if.tstrb;
            got.tkeep = m_if.tkeep;
            got.tlast = m_if.tlast;
            got.tid   = m_if.tid;
            got.tdest = m_if.tdest;
            got.tuser = m_if.tuser;
            n_popped++;
            if (exp_q.size() == 0) begin
                check("spurious_beat", 64'(m_if.tvalid), 64'd0);
            end else begin
                check("beat", 64'(got), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  bad;
        bit  done;
        areset      = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tstrb  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        s_if.tid    = '0;
        s_if.tdest  = '0;
        s_if.tuser  = '0;
        m_if.tready = 1'b0;

        // Reset state and release timing
        repeat (2) @(negedge aclk);
        check("rst_s_tready", 64'(s_if.tready), 64'd0);
        check("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_tdata", 64'(m_if.tdata), 64'd0);
        tick();
        areset = 1'b0;
        @(negedge aclk);
        check("ready_before_edge", 64'(s_if.tready), 64'd0);
        tick();
        @(negedge aclk);
        check("ready_after_edge", 64'(s_if.tready), 64'd1);
        check("level_idle", 64'(level), 64'd0);

        // Single beat with downstream ready
        m_if.tready = 1'b1;
        tick();
        send(mk(32'hABCD, 1'b1));
        @(negedge aclk);
        check("single_level1", 64'(level), 64'd1);
        check("single_tvalid", 64'(m_if.tvalid), 64'd1);
        check("single_tdata", 64'(m_if.tdata), 64'hABCD);
        check("single_tlast", 64'(m_if.tlast), 64'd1);
        @(negedge aclk);
        check("single_level0", 64'(level), 64'd0);
        check("single_tvalid0", 64'(m_if.tvalid), 64'd0);

        // Fill to DEPTH with downstream stalled, then drain
        m_if.tready = 1'b0;
        tick();
        for (int i = 0; i < DEPTH; i++) send(mk(32'(i), 1'b0));
        @(negedge aclk);
        check("full_level", 64'(level), 64'd16);
        check("full_s_tready", 64'(s_if.tready), 64'd0);
        check("full_m_tvalid", 64'(m_if.tvalid), 64'd1);
        check("full_head", 64'(m_if.tdata), 64'd0);
        tick();
        m_if.tready = 1'b1;
        @(negedge aclk);
        check("full_ready_pre_pop", 64'(s_if.tready), 64'd0);
        @(negedge aclk);
        check("full_ready_post_pop", 64'(s_if.tready), 64'd1);
        check("full_level_post_pop", 64'(level), 64'd15);
        wait_drain(100);
        @(negedge aclk);
        check("fill_level_end", 64'(level), 64'd0);

        // Streaming: one beat per cycle, level steady at 1
        m_if.tready = 1'b1;
        tick();
        bad = 0;
        fork
            begin
                for (int i = 0; i < 100; i++) send(mk(32'h1000 + 32'(i), 1'b1));
            end
            begin
                tick();
                repeat (100) begin
                    @(negedge aclk);
                    if (!(m_if.tvalid && level == 5'd1)) bad++;
                end
            end
        join
        check("stream_bubbles", 64'(bad), 64'd0);
        wait_drain(50);

        // Random traffic and backpressure on both sides
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    axis_beat_t b;
                    if ($urandom_range(0, 3) == 0) tick();
                    b       = mk($urandom, 1'b0);
                    b.tlast = (i == 999) ? 1'b1 : 1'($urandom_range(0, 1));
                    send(b);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    tick();
                    m_if.tready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        m_if.tready = 1'b1;
        wait_drain(200);
        check("beat_count", 64'(n_popped), 64'(n_pushed));

        // Reset with 5 beats of an unfinished packet stored
        m_if.tready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) send(mk(32'h200 + 32'(i), 1'b0));
        @(negedge aclk);
        check("pre_rst_level", 64'(level), 64'd5);
        areset = 1'b1;
        #1;
        check("midrst_tvalid", 64'(m_if.tvalid), 64'd0);
        check("midrst_level", 64'(level), 64'd0);
        check("midrst_s_tready", 64'(s_if.tready), 64'd0);
        check("midrst_tdata", 64'(m_if.tdata), 64'd0);
        exp_q.delete();
        repeat (2) tick();
        areset = 1'b0;
        tick();
        m_if.tready = 1'b1;
        send(mk(32'h1234, 1'b1));
        @(negedge aclk);
        check("post_rst_tvalid", 64'(m_if.tvalid), 64'd1);
        check("post_rst_first", 64'(m_if.tdata), 64'h1234);
        wait_drain(50);

`ifdef AXIS_FIFO_PKT_MODE_EN
        // Store-and-forward: nothing leaves until tlast is stored
        m_if.tready = 1'b1;
        tick();
        send(mk(32'h300, 1'b0));
        send(mk(32'h301, 1'b0));
        @(negedge aclk);
        check("pkt_hold_tvalid", 64'(m_if.tvalid), 64'd0);
        check("pkt_hold_level", 64'(level), 64'd2);
        tick();
        send(mk(32'h302, 1'b1));
        @(negedge aclk);
        check("pkt_release_tvalid", 64'(m_if.tvalid), 64'd1);
        check("pkt_release_head", 64'(m_if.tdata), 64'h300);
        wait_drain(50);

        // Full of one partial packet: cut-through release
        m_if.tready = 1'b0;
        tick();
        for (int i = 0; i < DEPTH - 1; i++) send(mk(32'h400 + 32'(i), 1'b0));
        @(negedge aclk);
        check("cut_wait_tvalid", 64'(m_if.tvalid), 64'd0);
        tick();
        send(mk(32'h40F, 1'b0));
        @(negedge aclk);
        check("cut_full_tvalid", 64'(m_if.tvalid), 64'd1);
        check("cut_full_level", 64'(level), 64'd16);
        tick();
        m_if.tready = 1'b1;
        wait_drain(100);
        send(mk(32'h4FF, 1'b1));
        wait_drain(50);
        @(negedge aclk);
        check("cut_level_end", 64'(level), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
